// File: rtl/coincidence_histogram_aligner.sv
// Per-phase occupancy histogram of sampled reference bits with circular rising-edge search.
// Define COINCIDENCE_HISTOGRAM_THRESHOLD_EN to add a programmable occupancy threshold input.
module coincidence_histogram_aligner #(
  parameter int CHANNEL_COUNT               = 2,
  parameter int SAMPLE_CLKS_PER_COINCIDENCE = 400,
  parameter int CYCLES_PER_ACQUISITION      = 7,
  parameter int MARGIN                      = 5,
  parameter int ADDR_WIDTH                  = $clog2(SAMPLE_CLKS_PER_COINCIDENCE),
  parameter int DATA_WIDTH                  = $clog2(CYCLES_PER_ACQUISITION + 1)
) (
  input  logic                                samplingClk_i,
  input  logic                                samplingReset_i,
  input  logic [CHANNEL_COUNT-1:0]            refBits_i,
  input  logic                                coincidenceMarker_i,
  input  logic                                start_i,
`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
  input  logic [DATA_WIDTH-1:0]               threshold_i,
`endif
  output logic                                busy_o,
  output logic                                done_o,
  input  logic [7:0]                          readChannel_i,
  input  logic [ADDR_WIDTH-1:0]               readAddress_i,
  output logic [DATA_WIDTH-1:0]               readData_o,
  output logic [CHANNEL_COUNT-1:0]            edgeValid_o,
  output logic [CHANNEL_COUNT-1:0]            noEdge_o,
  output logic [CHANNEL_COUNT-1:0]            multiEdge_o,
  output logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] edgeAddress_o,
  output logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] alignAddress_o,
  output logic                                markerError_o
);
  localparam int N  = SAMPLE_CLKS_PER_COINCIDENCE;
  localparam int C  = CYCLES_PER_ACQUISITION;
  localparam int CC = CHANNEL_COUNT;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] N_W  = CW'(N);
  localparam logic [CW-1:0] N_M1 = CW'(N - 1);
  localparam logic [CW-1:0] N_P1 = CW'(N + 1);
  localparam logic [CW-1:0] MARG = CW'(MARGIN);
  localparam logic [PW-1:0] C_M1 = PW'(C - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SYNC, S_ACQUIRE, S_SEARCH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ctr_q;
  logic [PW-1:0]   period_q;
  logic [DW-1:0]   thr_eff;
  logic [DW-1:0]   bin_q [CC][N];
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q [CC];
  logic            acq_en;
  logic [AW-1:0]   acq_phase, srch_addr;
  logic            scan_step, last_scan;
  logic [CC-1:0]   occ, rise, prev_q;
  logic [1:0]      cnt_q [CC];
  logic [1:0]      cnt_nx [CC];
  logic [AW-1:0]   first_q [CC];
  logic [AW-1:0]   edge_nx [CC];
  logic [AW-1:0]   align_nx [CC];
  logic [AW-1:0]   edge_q [CC];
  logic [AW-1:0]   align_q [CC];
  logic [CW-1:0]   diff [CC];
  logic [CC-1:0]   valid_q, none_q, multi_q;
  logic            done_q, merr_q;
  logic [DW-1:0]   rdata_q, rdata_d;

`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
  logic [DW-1:0] thr_q;
  always_ff @(posedge samplingClk_i) begin
    if (samplingReset_i) thr_q <= DW'(1);
    else if (state_q == S_IDLE && start_i) thr_q <= (threshold_i == '0) ? DW'(1) : threshold_i;
  end
  assign thr_eff = thr_q;
`else
  assign thr_eff = DW'(1);
`endif

  always_ff @(posedge samplingClk_i) begin
    if (samplingReset_i) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_CLEAR;
      S_CLEAR:   if (ctr_q == N_M1) state_d = S_SYNC;
      S_SYNC:    if (coincidenceMarker_i) state_d = S_ACQUIRE;
      S_ACQUIRE: if (ctr_q == N_M1 && period_q == C_M1) state_d = S_SEARCH;
      S_SEARCH:  if (ctr_q == N_P1) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != S_IDLE);
    edgeAddress_o  = '0;
    alignAddress_o = '0;
    for (int c = 0; c < CC; c++) begin
      edgeAddress_o[c*AW +: AW]  = edge_q[c];
      alignAddress_o[c*AW +: AW] = align_q[c];
    end
  end

  assign done_o        = done_q;
  assign edgeValid_o   = valid_q;
  assign noEdge_o      = none_q;
  assign multiEdge_o   = multi_q;
  assign markerError_o = merr_q;
  assign readData_o    = rdata_q;

  // The marker cycle itself is sampled as phase 0 while still in SYNC.
  assign acq_en    = (state_q == S_ACQUIRE) || (state_q == S_SYNC && coincidenceMarker_i);
  assign acq_phase = (state_q == S_ACQUIRE) ? ctr_q[AW-1:0] : '0;

  // Search counter: 0 drains the last write, 1 preloads prev from bin N-1, 2..N+1 scan 0..N-1.
  always_comb begin
    srch_addr = (ctr_q == CW'(1)) ? N_M1[AW-1:0] : (ctr_q[AW-1:0] - AW'(2));
    scan_step = (state_q == S_SEARCH) && (ctr_q >= CW'(2));
    last_scan = (state_q == S_SEARCH) && (ctr_q == N_P1);
    occ       = '0;
    rise      = '0;
    cnt_nx    = '{default: '0};
    edge_nx   = '{default: '0};
    diff      = '{default: '0};
    align_nx  = '{default: '0};
    for (int c = 0; c < CC; c++) begin
      occ[c]      = (bin_q[c][srch_addr] >= thr_eff);
      rise[c]     = scan_step && !prev_q[c] && occ[c];
      cnt_nx[c]   = (rise[c] && cnt_q[c] != 2'd2) ? cnt_q[c] + 2'd1 : cnt_q[c];
      edge_nx[c]  = (rise[c] && cnt_q[c] == 2'd0) ? srch_addr : first_q[c];
      diff[c]     = {1'b0, edge_nx[c]} - MARG;
      align_nx[c] = diff[c][AW] ? diff[c][AW-1:0] + N_W[AW-1:0] : diff[c][AW-1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (state_q == S_IDLE && {1'b0, readAddress_i} < N_W) begin
      for (int c = 0; c < CC; c++) begin
        if (readChannel_i == 8'(c)) rdata_d = bin_q[c][readAddress_i];
      end
    end
  end

  // Histogram storage has no reset; CLEAR defines it at the start of every run.
  always_ff @(posedge samplingClk_i) begin
    for (int c = 0; c < CC; c++) begin
      if (state_q == S_CLEAR)  bin_q[c][ctr_q[AW-1:0]] <= '0;
      else if (wr_en_q)        bin_q[c][wr_addr_q] <= wr_data_q[c];
    end
  end

  always_ff @(posedge samplingClk_i) begin
    if (samplingReset_i) begin
      ctr_q     <= '0;
      period_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      prev_q    <= '0;
      valid_q   <= '0;
      none_q    <= '0;
      multi_q   <= '0;
      done_q    <= 1'b0;
      merr_q    <= 1'b0;
      rdata_q   <= '0;
      for (int c = 0; c < CC; c++) begin
        wr_data_q[c] <= '0;
        cnt_q[c]     <= '0;
        first_q[c]   <= '0;
        edge_q[c]    <= '0;
        align_q[c]   <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      wr_en_q   <= acq_en;
      wr_addr_q <= acq_phase;
      rdata_q   <= rdata_d;
      for (int c = 0; c < CC; c++) wr_data_q[c] <= bin_q[c][acq_phase] + DW'(refBits_i[c]);
      case (state_q)
        S_IDLE: if (start_i) begin
          ctr_q   <= '0;
          valid_q <= '0;
          none_q  <= '0;
          multi_q <= '0;
          merr_q  <= 1'b0;
          for (int c = 0; c < CC; c++) begin
            edge_q[c]  <= '0;
            align_q[c] <= '0;
          end
        end
        S_CLEAR: ctr_q <= (ctr_q == N_M1) ? '0 : ctr_q + CW'(1);
        S_SYNC: if (coincidenceMarker_i) begin
          ctr_q    <= CW'(1);
          period_q <= '0;
        end
        S_ACQUIRE: begin
          if (coincidenceMarker_i && ctr_q != '0) merr_q <= 1'b1;
          if (ctr_q == N_M1) begin
            ctr_q    <= '0;
            period_q <= period_q + PW'(1);
          end else begin
            ctr_q <= ctr_q + CW'(1);
          end
        end
        S_SEARCH: begin
          ctr_q <= ctr_q + CW'(1);
          for (int c = 0; c < CC; c++) begin
            if (ctr_q == CW'(1)) begin
              prev_q[c]  <= occ[c];
              cnt_q[c]   <= '0;
              first_q[c] <= '0;
            end else if (scan_step) begin
              prev_q[c]  <= occ[c];
              cnt_q[c]   <= cnt_nx[c];
              first_q[c] <= edge_nx[c];
            end
            if (last_scan) begin
              none_q[c]  <= (cnt_nx[c] == 2'd0);
              valid_q[c] <= (cnt_nx[c] == 2'd1);
              multi_q[c] <= (cnt_nx[c] == 2'd2);
              edge_q[c]  <= edge_nx[c];
              align_q[c] <= align_nx[c];
            end
          end
          if (last_scan) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coincidence_histogram_aligner.sv
// Bench for coincidence_histogram_aligner: table vectors, hand sequences and random runs
// checked against a histogram/edge model built from the pattern applied.
`timescale 1ns/1ps
module tb_coincidence_histogram_aligner;
  localparam int CC = 2;
  localparam int N  = 400;
  localparam int C  = 7;
  localparam int M  = 5;
  localparam int AW = 9;
  localparam int DW = 3;

  typedef struct {
    int lo0a; int hi0a; int lo0b; int hi0b; int lo1; int hi1;
    bit [1:0] ev; bit [1:0] ne; bit [1:0] me;
    int e0; int a0; int e1; int a1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CC-1:0] ref_bits = '0;
  logic marker = 1'b0;
  logic start = 1'b0;
  logic [7:0] rd_ch = '0;
  logic [AW-1:0] rd_addr = '0;
  logic busy, done, merr;
  logic [DW-1:0] rd_data;
  logic [CC-1:0] ev, ne, me;
  logic [CC*AW-1:0] ea, aa;
`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
  logic [DW-1:0] thr_drive = DW'(1);
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  bit pat [CC][C][N];
  int hist [CC][N];
  bit [CC-1:0] m_ev, m_ne, m_me;
  int m_edge [CC];
  int m_align [CC];

  coincidence_histogram_aligner dut (
    .samplingClk_i(clk),
    .samplingReset_i(rst),
    .refBits_i(ref_bits),
    .coincidenceMarker_i(marker),
    .start_i(start),
`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
    .threshold_i(thr_drive),
`endif
    .busy_o(busy),
    .done_o(done),
    .readChannel_i(rd_ch),
    .readAddress_i(rd_addr),
    .readData_o(rd_data),
    .edgeValid_o(ev),
    .noEdge_o(ne),
    .multiEdge_o(me),
    .edgeAddress_o(ea),
    .alignAddress_o(aa),
    .markerError_o(merr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int eff_thr(input int t);
`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
    return (t == 0) ? 1 : t;
`else
    return 1;
`endif
  endfunction

  task automatic clear_pat();
    for (int c = 0; c < CC; c++)
      for (int p = 0; p < C; p++)
        for (int a = 0; a < N; a++) pat[c][p][a] = 1'b0;
  endtask

  // Inclusive, circular phase interval [lo,hi] high in periods p0..p1.
  task automatic set_iv(input int ch, input int p0, input int p1, input int lo, input int hi);
    for (int p = p0; p <= p1; p++)
      for (int a = 0; a < N; a++)
        if ((lo <= hi) ? (a >= lo && a <= hi) : (a >= lo || a <= hi)) pat[ch][p][a] = 1'b1;
  endtask

  task automatic model(input int thr);
    for (int c = 0; c < CC; c++) begin
      int cnt, first;
      bit prev, cur;
      for (int a = 0; a < N; a++) begin
        hist[c][a] = 0;
        for (int p = 0; p < C; p++) hist[c][a] += int'(pat[c][p][a]);
      end
      cnt = 0;
      first = 0;
      prev = (hist[c][N-1] >= thr);
      for (int a = 0; a < N; a++) begin
        cur = (hist[c][a] >= thr);
        if (!prev && cur) begin
          if (cnt == 0) first = a;
          cnt++;
        end
        prev = cur;
      end
      m_ne[c] = (cnt == 0);
      m_ev[c] = (cnt == 1);
      m_me[c] = (cnt >= 2);
      m_edge[c] = first;
      m_align[c] = (first - M + N) % N;
    end
  endtask

  task automatic rand_pat();
    clear_pat();
    for (int c = 0; c < CC; c++) begin
      int lo, len, lo2;
      lo = $urandom_range(0, N-1);
      case ($urandom_range(0, 3))
        0: begin
          len = $urandom_range(1, N-2);
          set_iv(c, 0, C-1, lo, (lo + len) % N);
        end
        1: begin
          len = $urandom_range(1, 50);
          lo2 = (lo + len + $urandom_range(2, 100)) % N;
          set_iv(c, 0, C-1, lo, (lo + len) % N);
          set_iv(c, 0, C-1, lo2, (lo2 + $urandom_range(1, 50)) % N);
        end
        2: for (int p = 0; p < C; p++)
             set_iv(c, p, p, (lo + $urandom_range(0, 3)) % N, (lo + 100) % N);
        default: for (int p = 0; p < C; p++)
                   for (int a = 0; a < N; a++) pat[c][p][a] = ($urandom_range(0, 19) == 0);
      endcase
    end
  endtask

  task automatic rd_exp(input string nm, input int ch, input int addr, input int exp);
    rd_ch = 8'(ch);
    rd_addr = AW'(addr);
    @(negedge clk);
    check(nm, int'(rd_data), exp);
  endtask

  task automatic run(input string nm, input int gap, input int extra_p, input int extra_ph,
                     input int start_at, input int rst_at, input int thr_in, output bit ok);
    int ks, d0;
    bit got;
    ok = 1'b0;
`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
    thr_drive = DW'(thr_in);
`endif
    rd_ch = 8'd0;
    rd_addr = AW'(150);
    @(negedge clk);
    start = 1'b1;
    ks = cyc;
    @(negedge clk);
    start = 1'b0;
    check({nm, " busy_rise"}, int'(busy), 1);
    repeat (N + gap) @(negedge clk);
    for (int i = 0; i < C*N; i++) begin
      int p, ph;
      p = i / N;
      ph = i % N;
      marker = (ph == 0) || (p == extra_p && ph == extra_ph);
      for (int c = 0; c < CC; c++) ref_bits[c] = pat[c][p][ph];
      start = (i == start_at);
      if (i == rst_at) begin
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        marker = 1'b0;
        start = 1'b0;
        check({nm, " rst_busy"}, int'(busy), 0);
        check({nm, " rst_done"}, int'(done), 0);
        check({nm, " rst_edgeValid"}, int'(ev), 0);
        check({nm, " rst_noEdge"}, int'(ne), 0);
        check({nm, " rst_multiEdge"}, int'(me), 0);
        check({nm, " rst_markerError"}, int'(merr), 0);
        check({nm, " rst_edgeAddress"}, int'(ea), 0);
        check({nm, " rst_alignAddress"}, int'(aa), 0);
        repeat (3*N) @(negedge clk);
        check({nm, " no_done_after_rst"}, done_cnt - d0, 0);
        check({nm, " idle_after_rst"}, int'(busy), 0);
        return;
      end
      if (i == 2000) check({nm, " readData_busy"}, int'(rd_data), 0);
      @(negedge clk);
    end
    marker = 1'b0;
    start = 1'b0;
    ref_bits = '0;
    got = 1'b0;
    for (int w = 0; w < 3*N && !got; w++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check({nm, " done_seen"}, int'(got), 1);
    if (!got) return;
    check({nm, " latency"}, cyc - ks, 1 + N + gap + C*N + N + 2);
    check({nm, " busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    check({nm, " done_one_cycle"}, int'(done), 0);
    ok = 1'b1;
  endtask

  task automatic check_results(input string nm, input int exp_merr);
    check({nm, " edgeValid"}, int'(ev), int'(m_ev));
    check({nm, " noEdge"}, int'(ne), int'(m_ne));
    check({nm, " multiEdge"}, int'(me), int'(m_me));
    check({nm, " markerError"}, int'(merr), exp_merr);
    for (int c = 0; c < CC; c++) begin
      if (m_ev[c] || m_me[c]) begin
        check($sformatf("%s edge%0d", nm, c), int'(ea[c*AW +: AW]), m_edge[c]);
        check($sformatf("%s align%0d", nm, c), int'(aa[c*AW +: AW]), m_align[c]);
      end
    end
    rd_exp({nm, " rd_ch0_150"}, 0, 150, hist[0][150]);
    rd_exp({nm, " rd_ch1_320"}, 1, 320, hist[1][320]);
    begin
      int ra;
      ra = $urandom_range(0, N-1);
      rd_exp({nm, " rd_ch0_rand"}, 0, ra, hist[0][ra]);
      rd_exp({nm, " rd_ch1_rand"}, 1, ra, hist[1][ra]);
    end
    rd_exp({nm, " rd_bad_channel"}, 2, 150, 0);
  endtask

  initial begin
    vec_t vt [5];
    bit ok;
    int d0;
    vt[0] = '{100, 199, -1, -1, 300, 349, 2'b11, 2'b00, 2'b00, 100, 95, 300, 295};
    vt[1] = '{395, 9, -1, -1, -1, -1, 2'b01, 2'b10, 2'b00, 395, 390, 0, 0};
    vt[2] = '{2, 20, -1, -1, 0, 399, 2'b01, 2'b10, 2'b00, 2, 397, 0, 0};
    vt[3] = '{-1, -1, -1, -1, 0, 399, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0};
    vt[4] = '{10, 19, 200, 209, 300, 349, 2'b10, 2'b00, 2'b01, 10, 5, 300, 295};

    repeat (4) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset flags", int'({ev, ne, me}), 0);
    check("reset markerError", int'(merr), 0);
    check("reset edgeAddress", int'(ea), 0);
    check("reset alignAddress", int'(aa), 0);
    check("reset readData", int'(rd_data), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      clear_pat();
      if (vt[v].lo0a >= 0) set_iv(0, 0, C-1, vt[v].lo0a, vt[v].hi0a);
      if (vt[v].lo0b >= 0) set_iv(0, 0, C-1, vt[v].lo0b, vt[v].hi0b);
      if (vt[v].lo1 >= 0)  set_iv(1, 0, C-1, vt[v].lo1, vt[v].hi1);
      model(1);
      m_ev = vt[v].ev;
      m_ne = vt[v].ne;
      m_me = vt[v].me;
      m_edge[0] = vt[v].e0;
      m_align[0] = vt[v].a0;
      m_edge[1] = vt[v].e1;
      m_align[1] = vt[v].a1;
      run(nm, 3, -1, -1, -1, -1, 1, ok);
      if (ok) check_results(nm, 0);
      if (v == 0) begin
        rd_exp("vec0 ch0@150 full", 0, 150, 7);
        rd_exp("vec0 ch0@50 empty", 0, 50, 0);
      end
    end

    // Stray marker mid-acquisition: sticky error, histogram untouched.
    clear_pat();
    set_iv(0, 0, C-1, 100, 199);
    set_iv(1, 0, C-1, 300, 349);
    model(1);
    run("marker_err", 7, 3, 37, -1, -1, 1, ok);
    if (ok) begin
      check_results("marker_err", 1);
      check("marker_err edge0", int'(ea[AW-1:0]), 100);
    end

    // start during ACQUIRE must be ignored.
    d0 = done_cnt;
    run("start_acq", 0, -1, -1, 500, -1, 1, ok);
    if (ok) check_results("start_acq", 0);
    repeat (10) @(negedge clk);
    check("start_acq done_count", done_cnt - d0, 1);

    run("reset_mid", 2, -1, -1, -1, 1000, 1, ok);

    run("after_reset", 5, -1, -1, -1, -1, 1, ok);
    if (ok) check_results("after_reset", 0);

    for (int r = 0; r < 3; r++) begin
      string nm;
      int thr_in;
      nm = $sformatf("rand%0d", r);
      thr_in = (r == 0) ? 0 : 1;
      rand_pat();
      model(eff_thr(thr_in));
      run(nm, $urandom_range(0, 20), -1, -1, -1, -1, thr_in, ok);
      if (ok) check_results(nm, 0);
    end

`ifdef COINCIDENCE_HISTOGRAM_THRESHOLD_EN
    clear_pat();
    set_iv(0, 0, 2, 100, 199);
    set_iv(0, 3, C-1, 120, 199);
    model(4);
    run("threshold4", 4, -1, -1, -1, -1, 4, ok);
    if (ok) begin
      check_results("threshold4", 0);
      check("threshold4 edge0", int'(ea[AW-1:0]), 120);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
